// File: rtl/shift_arb_ctrl.sv
// Round-robin sequencer sharing one universal shift register between two requesters:
// load, N shifts, drain, then a tagged one-cycle result pulse.
module shift_arb_ctrl #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_dir,
    input  logic [LEN_W-1:0] req0_len,
    input  logic             req0_fill,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_dir,
    input  logic [LEN_W-1:0] req1_len,
    input  logic             req1_fill,
    output logic             sh_en,
    output logic [1:0]       sh_sel,
    output logic [WIDTH-1:0] sh_pin,
    output logic             sh_sin,
    input  logic [WIDTH-1:0] sh_pout,
    output logic             busy,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_r;
    logic               last_grant_r;
    logic               arm_r;
    logic               id_r;
    logic               dir_r;
    logic               fill_r;
    logic [WIDTH-1:0]   data_r;
    logic [CNT_W-1:0]   cnt_r;

    logic               grant0_s;
    logic               grant1_s;
    logic [WIDTH-1:0]   sel_data_s;
    logic               sel_dir_s;
    logic               sel_fill_s;
    logic [LEN_W-1:0]   sel_len_s;

    function automatic logic [CNT_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        logic [CNT_W-1:0] res;
        if (32'(len) > 32'(WIDTH)) begin
            res = CNT_W'(WIDTH);
        end else begin
            res = CNT_W'(len);
        end
        return res;
    endfunction

    function automatic logic [1:0] shift_sel(input logic dir);
        logic [1:0] res;
        if (dir) begin
            res = 2'b10;
        end else begin
            res = 2'b01;
        end
        return res;
    endfunction

    // Grant decode: arm_r keeps ready low through reset and the first edge after it.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (arm_r && (state_r == IDLE)) begin
            if (req0_valid && req1_valid) begin
                grant0_s = last_grant_r;
                grant1_s = ~last_grant_r;
            end else begin
                grant0_s = req0_valid;
                grant1_s = req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Mux the granted requester's command fields.
    always_comb begin
        sel_data_s = req0_data;
        sel_dir_s  = req0_dir;
        sel_fill_s = req0_fill;
        sel_len_s  = req0_len;
        if (grant1_s) begin
            sel_data_s = req1_data;
            sel_dir_s  = req1_dir;
            sel_fill_s = req1_fill;
            sel_len_s  = req1_len;
        end else begin
            sel_data_s = req0_data;
            sel_dir_s  = req0_dir;
            sel_fill_s = req0_fill;
            sel_len_s  = req0_len;
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    // Sequencer: shifter controls are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            arm_r        <= 1'b0;
            id_r         <= 1'b0;
            dir_r        <= 1'b0;
            fill_r       <= 1'b0;
            data_r       <= {WIDTH{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            sh_en        <= 1'b0;
            sh_sel       <= 2'b00;
            sh_pin       <= {WIDTH{1'b0}};
            sh_sin       <= 1'b0;
            busy         <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_data     <= {WIDTH{1'b0}};
        end else begin
            arm_r     <= 1'b1;
            rsp_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant0_s || grant1_s) begin
                        id_r         <= grant1_s;
                        data_r       <= sel_data_s;
                        dir_r        <= sel_dir_s;
                        fill_r       <= sel_fill_s;
                        cnt_r        <= sat_len(sel_len_s);
                        last_grant_r <= grant1_s;
                        state_r      <= LOAD;
                        sh_en        <= 1'b1;
                        sh_sel       <= 2'b11;
                        sh_pin       <= sel_data_s;
                        sh_sin       <= 1'b0;
                        busy         <= 1'b1;
                    end else begin
                        sh_en  <= 1'b0;
                        sh_sel <= 2'b00;
                        sh_pin <= {WIDTH{1'b0}};
                        sh_sin <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                LOAD: begin
                    sh_en  <= 1'b1;
                    sh_pin <= {WIDTH{1'b0}};
                    busy   <= 1'b1;
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        state_r <= SHIFT;
                        sh_sel  <= shift_sel(dir_r);
                        sh_sin  <= fill_r;
                    end else begin
                        state_r <= DRAIN;
                        sh_sel  <= 2'b00;
                        sh_sin  <= 1'b0;
                    end
                end
                SHIFT: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= DRAIN;
                        sh_sel  <= 2'b00;
                        sh_sin  <= 1'b0;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DRAIN: begin
                    state_r <= DONE;
                    sh_en   <= 1'b0;
                    sh_sel  <= 2'b00;
                end
                DONE: begin
                    // sh_pout now holds the final word captured during DRAIN.
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_r;
                    rsp_data  <= sh_pout;
                    state_r   <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    sh_en   <= 1'b0;
                    sh_sel  <= 2'b00;
                    sh_pin  <= {WIDTH{1'b0}};
                    sh_sin  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Bench for shift_arb_ctrl: behavioural shifter, directed plan cases and
// randomized commands checked against an arithmetic reference model.
module tb_shift_arb_ctrl;

    typedef struct packed {
        logic [7:0] data;
        logic       dir;
        logic [3:0] len;
        logic       fill;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_dir = 1'b0, req1_dir = 1'b0;
    logic [3:0] req0_len = 4'h0, req1_len = 4'h0;
    logic       req0_fill = 1'b0, req1_fill = 1'b0;
    logic       sh_en, sh_sin, busy, rsp_valid, rsp_id;
    logic [1:0] sh_sel;
    logic [7:0] sh_pin, sh_pout, rsp_data;
    logic [7:0] sreg;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_last = 1'b1;

    shift_arb_ctrl #(.WIDTH(8), .LEN_W(4)) dut (
        .clk(clk), .rst_(rst_),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_dir(req0_dir), .req0_len(req0_len), .req0_fill(req0_fill),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_dir(req1_dir), .req1_len(req1_len), .req1_fill(req1_fill),
        .sh_en(sh_en), .sh_sel(sh_sel), .sh_pin(sh_pin), .sh_sin(sh_sin),
        .sh_pout(sh_pout), .busy(busy),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    // Universal shifter with registered parallel output, sharing rst_.
    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            sreg    <= 8'h00;
            sh_pout <= 8'h00;
        end else if (sh_en) begin
            sh_pout <= sreg;
            case (sh_sel)
                2'b01:   sreg <= {sh_sin, sreg[7:1]};
                2'b10:   sreg <= {sreg[6:0], sh_sin};
                2'b11:   sreg <= sh_pin;
                default: sreg <= sreg;
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int eff_len(input cmd_t c);
        return (c.len > 4'd8) ? 8 : int'(c.len);
    endfunction

    function automatic logic [7:0] ref_result(input cmd_t c);
        int l = eff_len(c);
        int w = int'(c.data);
        int m = (1 << l) - 1;
        int r;
        if (!c.dir) r = (w >> l) | (c.fill ? (m << (8 - l)) : 0);
        else        r = ((w << l) | (c.fill ? m : 0)) & 255;
        return 8'(r);
    endfunction

    function automatic logic [24:0] all_outs();
        return {sh_en, sh_sel, sh_pin, sh_sin, busy, rsp_valid, rsp_id, rsp_data,
                req0_ready, req1_ready};
    endfunction

    function automatic cmd_t mk(input logic [7:0] d, input logic dr, input logic [3:0] l,
                                input logic f);
        cmd_t c;
        c.data = d; c.dir = dr; c.len = l; c.fill = f;
        return c;
    endfunction

    task automatic do_reset();
        rst_ = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        check_val("reset_outs", 32'(all_outs()), 32'h0);
        rst_ = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        exp_last = 1'b1;
    endtask

    // Issue one command (called on a negedge); abort_cyc > 0 pulls reset in that cycle.
    task automatic issue(input bit v0, input bit v1, input cmd_t c0, input cmd_t c1,
                         input int abort_cyc);
        bit   got = 1'b0;
        bit   g;
        cmd_t c;
        int   l;
        logic [7:0]  expd;
        logic [15:0] ctl_exp;
        req0_valid = v0; req0_data = c0.data; req0_dir = c0.dir; req0_len = c0.len; req0_fill = c0.fill;
        req1_valid = v1; req1_data = c1.data; req1_dir = c1.dir; req1_len = c1.len; req1_fill = c1.fill;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req0_ready || req1_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            check_val("handshake_timeout", 32'd0, 32'd1);
            return;
        end
        g = (v0 && v1) ? ~exp_last : !v0;
        check_val("ready_pair", {30'd0, req0_ready, req1_ready}, {30'd0, !g, g});
        exp_last = g;
        c = g ? c1 : c0;
        l = eff_len(c);
        expd = ref_result(c);
        @(posedge clk);
        #1;
        req0_data = 8'($urandom); req0_len = 4'($urandom); req0_dir = 1'($urandom); req0_fill = 1'($urandom);
        req1_data = 8'($urandom); req1_len = 4'($urandom); req1_dir = 1'($urandom); req1_fill = 1'($urandom);
        for (int cyc = 1; cyc <= l + 4; cyc++) begin
            @(negedge clk);
            if (cyc == abort_cyc) begin
                rst_ = 1'b0;
                #1;
                check_val("abort_outs", 32'(all_outs()), 32'h0);
                return;
            end
            // {busy, en, sel, sin, rdy0, rdy1, rsp_valid, pin}
            ctl_exp = 16'h0;
            if (cyc <= l + 3) ctl_exp[15] = 1'b1;
            if (cyc <= l + 2) ctl_exp[14] = 1'b1;
            if (cyc == 1) begin
                ctl_exp[13:12] = 2'b11;
                ctl_exp[7:0]   = c.data;
            end else if (cyc <= l + 1) begin
                ctl_exp[13:12] = c.dir ? 2'b10 : 2'b01;
                ctl_exp[11]    = c.fill;
            end
            if (cyc == l + 4) begin
                ctl_exp[10]  = req0_ready;
                ctl_exp[9]   = req1_ready;
                ctl_exp[8]   = 1'b1;
            end
            check_val($sformatf("ctl_cyc%0d", cyc),
                      {16'd0, busy, sh_en, sh_sel, sh_sin, req0_ready, req1_ready, rsp_valid, sh_pin},
                      {16'd0, ctl_exp});
        end
        check_val("rsp_id", {31'd0, rsp_id}, {31'd0, g});
        check_val("rsp_data", {24'd0, rsp_data}, {24'd0, expd});
    endtask

    initial begin
        cmd_t  ca, cb;
        bit    v0, v1;
        int    r;
        @(negedge clk);
        do_reset();
        // Plan cases
        issue(1'b1, 1'b0, mk(8'hA5, 1'b0, 4'd3, 1'b0), mk(8'h00, 1'b0, 4'd0, 1'b0), 0);
        issue(1'b0, 1'b1, mk(8'h00, 1'b0, 4'd0, 1'b0), mk(8'h81, 1'b1, 4'd2, 1'b1), 0);
        issue(1'b1, 1'b0, mk(8'h3C, 1'b1, 4'd0, 1'b1), mk(8'h00, 1'b0, 4'd0, 1'b0), 0);
        issue(1'b0, 1'b1, mk(8'h00, 1'b0, 4'd0, 1'b0), mk(8'h00, 1'b0, 4'd12, 1'b1), 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            issue(1'b1, 1'b1, mk(8'h0F, 1'b0, 4'd1, 1'b0), mk(8'hF0, 1'b0, 4'd1, 1'b0), 0);
        end
        // Reset in the middle of a shift sequence
        issue(1'b0, 1'b1, mk(8'h11, 1'b0, 4'd2, 1'b0), mk(8'h5A, 1'b1, 4'd6, 1'b0), 4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("no_rsp_in_reset", {31'd0, rsp_valid}, 32'd0);
        end
        rst_ = 1'b1;
        exp_last = 1'b1;
        issue(1'b1, 1'b1, mk(8'hC3, 1'b1, 4'd5, 1'b0), mk(8'h99, 1'b0, 4'd4, 1'b1), 0);
        // Randomized commands, back-to-back
        for (int k = 0; k < 40; k++) begin
            r  = $urandom_range(1, 3);
            v0 = r[0];
            v1 = r[1];
            ca = mk(8'($urandom), 1'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
            cb = mk(8'($urandom), 1'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
            issue(v0, v1, ca, cb, 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check_val("final_idle", {30'd0, rsp_valid, busy}, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_arb_ctrl.md
Name: shift_arb_ctrl

Overview:
- Sequencer and round-robin arbiter that shares one 8-bit universal shift register (en/sel/pin/sin in, pout out) between two requesters.
- Each requester submits a command: load word, shift direction, shift count and fill bit.
- The block drives the shifter through load, N shifts and a drain cycle, then returns the resulting word with a one-cycle response pulse tagged with the requester id.

Parameters:
- WIDTH, 8, data width of shifter word and command data.
- LEN_W, 4, width of shift-count field; effective count saturates at WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_  input  1  reset, asynchronous, active-low.
- req0_valid  input  1  requester 0 command valid.
- req0_ready  output  1  requester 0 command accepted (handshake when valid&ready at clk edge).
- req0_data  input  WIDTH  word to parallel-load.
- req0_dir  input  1  0 = shift right (sel 01), 1 = shift left (sel 10).
- req0_len  input  LEN_W  number of shift cycles.
- req0_fill  input  1  serial fill bit driven on sh_sin during shifts.
- req1_valid, req1_ready, req1_data, req1_dir, req1_len, req1_fill: same as requester 0.
- sh_en  output  1  shifter enable.
- sh_sel  output  2  shifter mode: 00 hold, 01 right, 10 left, 11 load.
- sh_pin  output  WIDTH  shifter parallel-load data.
- sh_sin  output  1  shifter serial input.
- sh_pout  input  WIDTH  shifter parallel output (registered, lags the internal register by one enabled cycle).
- busy  output  1  high in every state except IDLE.
- rsp_valid  output  1  one-cycle result pulse, no backpressure.
- rsp_id  output  1  requester id of the result.
- rsp_data  output  WIDTH  final shifted word.

Behaviour:
- Reset (rst_ low, asynchronous):
  - state = IDLE, last_grant = 1 (so requester 0 wins first), cnt = 0.
  - rsp_valid, rsp_id, rsp_data, busy, sh_en, sh_sel, sh_pin, sh_sin and both ready outputs all 0.
  - Reset mid-operation aborts the command with no response. The shifter shares rst_.
- sh_* and busy: decoded from registered state and latched command only, never directly from requester inputs.
- IDLE:
  - sh_en = 0.
  - Only one valid: assert that requester's ready.
  - Both valid: grant the requester that is not last_grant.
  - On handshake edge:
    - latch data/dir/fill/id.
    - cnt = min(len, WIDTH).
    - last_grant = id.
    - go to LOAD.
  - The non-granted ready stays 0. Ready is 0 in all non-IDLE states.
- LOAD (1 cycle): sh_en = 1, sh_sel = 11, sh_pin = latched data. Next state is SHIFT if cnt != 0, else DRAIN.
- SHIFT (cnt cycles):
  - sh_en = 1, sh_sel = 01 if dir = 0 else 10, sh_sin = fill.
  - cnt decrements each edge. Go to DRAIN on the edge where cnt == 1.
- DRAIN (1 cycle): sh_en = 1, sh_sel = 00. The shifter's pout captures its final register value.
- DONE (1 cycle):
  - sh_en = 0.
  - On the exit edge: rsp_data <= sh_pout, rsp_id <= id, rsp_valid <= 1; state -> IDLE.
  - rsp_valid clears on the following edge.
- Latency: rsp_valid is high in cycle (L + 4) after the accept edge, where L = min(len, WIDTH). The cycle right after the accept edge is cycle 1.
- Back-to-back operation:
  - A new command can be accepted in the IDLE cycle that coincides with rsp_valid.
  - Minimum issue interval is L + 4 cycles.
- Len saturation: len > WIDTH behaves as WIDTH (e.g. 12 -> 8).
- Requester inputs may change after the handshake without effect.
- sh_pin = 0 and sh_sin = 0 outside LOAD and SHIFT respectively.

Test Plan:
- After reset, requester 0 sends data 0xA5, dir 0, len 3, fill 0 -> sh_sel sequence 11, 01, 01, 01, 00; rsp_valid high 7 cycles after accept; rsp_id 0; rsp_data 0x14.
- Requester 1 sends data 0x81, dir 1, len 2, fill 1 -> rsp_data 0x07, rsp_id 1, latency 6 cycles.
- len 0, data 0x3C -> no SHIFT cycles; rsp_data 0x3C after 4 cycles.
- len 12, dir 0, fill 1, data 0x00 -> exactly 8 shift cycles; rsp_data 0xFF.
- Both requesters valid continuously from reset (req0 data 0x0F, req1 data 0xF0, len 1, dir 0, fill 0) -> grants alternate 0, 1, 0, 1; rsp_data alternates 0x07 and 0x78; never two readies high at once.
- Assert rst_ low during SHIFT -> all outputs 0 immediately; no rsp_valid; the next command completes normally with requester 0 granted first.
